// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for a symbol-memory game.
// Arms the countdown timer, generates an LFSR symbol sequence, presents it
// one symbol per tick1Hz period, then checks the player's guesses.
// Optional build macro: SYM_TIMEOUT_EN -- when defined, INPUT_TIMEOUT
// consecutive tick1Hz periods without a guess in INPUT lose the game.
module game_round_ctrl #(
    parameter int unsigned MAX_LEVEL     = 9,
    parameter int unsigned INPUT_TIMEOUT = 5,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       Clk100M,
    input  logic       reset,
    input  logic       tick1Hz,
    input  logic       startBtn,
    input  logic       timerDone,
    input  logic       guessValid,
    input  logic [1:0] guessSym,
    output logic       timerStart,
    output logic [3:0] curLevel,
    output logic       showValid,
    output logic [1:0] showSym,
    output logic       gameOver,
    output logic       win,
    output logic [2:0] state
);

    localparam int unsigned LVL_W  = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SYM_W  = 2;
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned DEPTH  = 16;

    // Reject parameter values outside the playable range at elaboration
    if (MAX_LEVEL == 0 || MAX_LEVEL > 9 || INPUT_TIMEOUT == 0 || LFSR_SEED == 8'h00) begin : g_bad_params
        $error("game_round_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_TMR = 3'd2,
        S_GEN      = 3'd3,
        S_SHOW     = 3'd4,
        S_INPUT    = 3'd5,
        S_LOSE     = 3'd6,
        S_WIN      = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic                btn_prev_q;
    logic [SYM_W-1:0]    mem_q [DEPTH];
    logic                mem_we;
    logic                timer_start_q, timer_start_d;
    logic                show_valid_q, show_valid_d;
    logic [SYM_W-1:0]    show_sym_q, show_sym_d;
    logic                game_over_q, game_over_d;
    logic                win_q, win_d;
    logic                start_ev;
    logic [IDX_W-1:0]    last_idx;
    logic [SYM_W-1:0]    cur_sym;

`ifdef SYM_TIMEOUT_EN
    localparam int unsigned TMO_W = (INPUT_TIMEOUT < 2) ? 1 : $clog2(INPUT_TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    assign start_ev = startBtn & ~btn_prev_q;
    // Sequence length is level+2, so the last index is level+1
    assign last_idx = IDX_W'(level_q) + IDX_W'(1);
    assign cur_sym  = mem_q[idx_q];
    // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        idx_d    = idx_q;
        mem_we   = 1'b0;
`ifdef SYM_TIMEOUT_EN
        tmo_d    = '0;
`endif
        case (state_q)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start_ev) begin
                    state_d = S_ARM;
                    level_d = LVL_W'(1);
                end
            end
            S_ARM: begin
                state_d = S_WAIT_TMR;
                idx_d   = '0;
            end
            S_WAIT_TMR: begin
                if (timerDone) begin
                    state_d = S_GEN;
                    idx_d   = '0;
                end
            end
            S_GEN: begin
                mem_we = 1'b1;
                if (idx_q == last_idx) begin
                    state_d = S_SHOW;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_SHOW: begin
                if (tick1Hz) begin
                    if (idx_q == last_idx) begin
                        state_d = S_INPUT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_INPUT: begin
`ifdef SYM_TIMEOUT_EN
                tmo_d = tmo_q;
`endif
                if (guessValid) begin
`ifdef SYM_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (guessSym != cur_sym) begin
                        state_d = S_LOSE;
                    end else if (idx_q == last_idx) begin
                        idx_d = '0;
                        if (level_q == LVL_W'(MAX_LEVEL)) begin
                            state_d = S_WIN;
                        end else begin
                            state_d = S_ARM;
                            level_d = level_q + LVL_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef SYM_TIMEOUT_EN
                else if (tick1Hz) begin
                    if (tmo_q == TMO_W'(INPUT_TIMEOUT - 1)) begin
                        state_d = S_LOSE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        timer_start_d = (state_d == S_ARM);
        show_valid_d  = (state_d == S_SHOW);
        show_sym_d    = show_valid_d ? mem_q[idx_d] : '0;
        game_over_d   = (state_d == S_LOSE);
        win_d         = (state_d == S_WIN);
    end

    // State, control registers and registered outputs
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            state_q       <= S_IDLE;
            level_q       <= LVL_W'(1);
            idx_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            btn_prev_q    <= 1'b1;
            timer_start_q <= 1'b0;
            show_valid_q  <= 1'b0;
            show_sym_q    <= '0;
            game_over_q   <= 1'b0;
            win_q         <= 1'b0;
`ifdef SYM_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            idx_q         <= idx_d;
            lfsr_q        <= lfsr_d;
            btn_prev_q    <= startBtn;
            timer_start_q <= timer_start_d;
            show_valid_q  <= show_valid_d;
            show_sym_q    <= show_sym_d;
            game_over_q   <= game_over_d;
            win_q         <= win_d;
`ifdef SYM_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    // Sequence storage, written only while generating
    always_ff @(posedge Clk100M) begin
        if (mem_we) begin
            mem_q[idx_q] <= lfsr_q[1:0];
        end
    end

    assign timerStart = timer_start_q;
    assign curLevel   = level_q;
    assign showValid  = show_valid_q;
    assign showSym    = show_sym_q;
    assign gameOver   = game_over_q;
    assign win        = win_q;
    assign state      = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl (MAX_LEVEL=2), timeout build aware.
module tb_game_round_ctrl;

    logic       Clk100M = 1'b0;
    logic       reset = 1'b1;
    logic       tick1Hz = 1'b0;
    logic       startBtn = 1'b0;
    logic       timerDone = 1'b0;
    logic       guessValid = 1'b0;
    logic [1:0] guessSym = 2'd0;
    logic       timerStart;
    logic [3:0] curLevel;
    logic       showValid;
    logic [1:0] showSym;
    logic       gameOver;
    logic       win;
    logic [2:0] state;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] lfsr_m = 8'hA5;
    logic [1:0] seq [$];

    localparam int ST_IDLE = 0, ST_ARM = 1, ST_WAIT = 2, ST_GEN = 3,
                   ST_SHOW = 4, ST_INPUT = 5, ST_LOSE = 6, ST_WIN = 7;

    game_round_ctrl #(.MAX_LEVEL(2), .INPUT_TIMEOUT(5), .LFSR_SEED(8'hA5)) dut (
        .Clk100M(Clk100M), .reset(reset), .tick1Hz(tick1Hz), .startBtn(startBtn),
        .timerDone(timerDone), .guessValid(guessValid), .guessSym(guessSym),
        .timerStart(timerStart), .curLevel(curLevel), .showValid(showValid),
        .showSym(showSym), .gameOver(gameOver), .win(win), .state(state)
    );

    always #5 Clk100M = ~Clk100M;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: reference LFSR follows the register (seed on reset, else shift)
    task automatic step();
        logic rst_now;
        rst_now = reset;
        @(posedge Clk100M);
        #1;
        lfsr_m = rst_now ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        tick1Hz    = 1'b0;
        timerDone  = 1'b0;
        guessValid = 1'b0;
    endtask

    task automatic guess(input logic [1:0] s);
        guessValid = 1'b1;
        guessSym   = s;
        step();
    endtask

    task automatic start_press();
        startBtn = 1'b0;
        step();
        startBtn = 1'b1;
        step();
    endtask

    // From ARM through GEN and SHOW; stop_at >= 0 returns while showing that entry
    task automatic run_to_input(input int lvl, input int stop_at);
        int n;
        chk("arm_state", 32'(state), ST_ARM);
        chk("arm_tstart", 32'(timerStart), 1);
        chk("arm_level", 32'(curLevel), 32'(lvl));
        step();
        chk("wait_state", 32'(state), ST_WAIT);
        chk("tstart_once", 32'(timerStart), 0);
        repeat ($urandom_range(1, 4)) begin
            tick1Hz    = 1'($urandom_range(0, 1));
            guessValid = 1'b1;
            guessSym   = 2'($urandom_range(0, 3));
            startBtn   = 1'($urandom_range(0, 1));
            step();
            chk("wait_hold", 32'(state), ST_WAIT);
        end
        timerDone = 1'b1;
        step();
        seq.delete();
        n = 0;
        while (state == 3'(ST_GEN) && n < 20) begin
            seq.push_back(lfsr_m[1:0]);
            n++;
            step();
        end
        chk("gen_len", 32'(n), 32'(lvl + 2));
        chk("show_state", 32'(state), ST_SHOW);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                chk("show_valid", 32'(showValid), 1);
                chk("show_sym_hold", 32'(showSym), 32'(seq[i]));
                step();
            end
            chk("show_sym", 32'(showSym), 32'(seq[i]));
            if (i == stop_at) return;
            tick1Hz = 1'b1;
            step();
        end
        chk("input_state", 32'(state), ST_INPUT);
        chk("input_noshow", 32'(showValid), 0);
    endtask

    // Enter all guesses correctly, with idle gaps that carry no tick
    task automatic guess_all();
        for (int i = 0; i < seq.size(); i++) begin
            repeat ($urandom_range(0, 2)) step();
            guess(seq[i]);
            if (i < seq.size() - 1) chk("guess_adv", 32'(state), ST_INPUT);
        end
    endtask

    initial begin
        logic [1:0] wrong;
        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_state", 32'(state), ST_IDLE);
        chk("rst_level", 32'(curLevel), 1);
        chk("rst_tstart", 32'(timerStart), 0);
        chk("rst_showv", 32'(showValid), 0);
        chk("rst_shows", 32'(showSym), 0);
        chk("rst_over", 32'(gameOver), 0);
        chk("rst_win", 32'(win), 0);
        reset = 1'b0;
        step();
        timerDone = 1'b1;
        step();
        chk("idle_tdone", 32'(state), ST_IDLE);

        // Level 1 then level 2 all correct -> WIN at MAX_LEVEL=2
        start_press();
        run_to_input(1, -1);
        guess_all();
        chk("lvlup_state", 32'(state), ST_ARM);
        chk("lvlup_level", 32'(curLevel), 2);
        chk("lvlup_tstart", 32'(timerStart), 1);
        run_to_input(2, -1);
        guess_all();
        chk("win_state", 32'(state), ST_WIN);
        chk("win_flag", 32'(win), 1);
        chk("win_level", 32'(curLevel), 2);
        chk("win_tstart", 32'(timerStart), 0);
        repeat (3) begin
            guess(2'($urandom_range(0, 3)));
            chk("win_hold", 32'(win), 1);
        end

        // Restart from WIN, lose on the second guess
        start_press();
        run_to_input(1, -1);
        guess(seq[0]);
        chk("first_ok", 32'(state), ST_INPUT);
        wrong = seq[1] ^ 2'($urandom_range(1, 3));
        guess(wrong);
        chk("lose_state", 32'(state), ST_LOSE);
        chk("lose_over", 32'(gameOver), 1);
        chk("lose_noshow", 32'(showValid), 0);
        guess(seq[1]);
        timerDone = 1'b1;
        step();
        chk("lose_hold", 32'(state), ST_LOSE);
        chk("lose_tstart", 32'(timerStart), 0);
        start_press();
        chk("lose_restart_lvl", 32'(curLevel), 1);

        // Idle behaviour in INPUT
        run_to_input(1, -1);
`ifdef SYM_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) step();
            tick1Hz = 1'b1;
            step();
        end
        chk("tmo_4ticks", 32'(state), ST_INPUT);
        tick1Hz    = 1'b1;
        guessValid = 1'b1;
        guessSym   = seq[0];
        step();
        chk("tmo_guess_saves", 32'(state), ST_INPUT);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) step();
            tick1Hz = 1'b1;
            step();
        end
        chk("tmo_cleared", 32'(state), ST_INPUT);
        tick1Hz = 1'b1;
        step();
        chk("tmo_lose", 32'(state), ST_LOSE);
        chk("tmo_over", 32'(gameOver), 1);
`else
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 2)) step();
            tick1Hz = 1'b1;
            step();
        end
        chk("notmo_state", 32'(state), ST_INPUT);
        start_press();
        chk("start_ignored", 32'(state), ST_INPUT);
`endif

        // Reset with startBtn held high: no start until it drops
        reset    = 1'b1;
        startBtn = 1'b1;
        step();
        chk("rst2_state", 32'(state), ST_IDLE);
        reset = 1'b0;
        step();
        step();
        chk("held_btn_idle", 32'(state), ST_IDLE);
        start_press();

        // Reset mid-SHOW at entry 2
        run_to_input(1, 2);
        chk("mid_show", 32'(state), ST_SHOW);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_state", 32'(state), ST_IDLE);
        chk("midrst_showv", 32'(showValid), 0);
        chk("midrst_level", 32'(curLevel), 1);
        chk("midrst_shows", 32'(showSym), 0);
        timerDone = 1'b1;
        step();
        chk("midrst_tdone", 32'(state), ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter MAX_LEVEL, default 9, last playable level (1..9).
REQ-002 Parameter INPUT_TIMEOUT, default 5, allowed tick1Hz periods between guesses.
REQ-003 Parameter LFSR_SEED, default 8'hA5, LFSR reset value; nonzero.
REQ-004 Clk100M  in  1  sole clock; every register updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 tick1Hz  in  1  one-cycle enable, once per second, Clk100M domain.
REQ-007 startBtn  in  1  debounced level; rising edge detected internally.
REQ-008 timerDone  in  1  one-cycle pulse from countdown timer on completion.
REQ-009 guessValid  in  1  one-cycle strobe qualifying guessSym.
REQ-010 guessSym  in  2  player's symbol, 0..3.
REQ-011 timerStart  out  1  one-cycle pulse that starts the countdown timer.
REQ-012 curLevel  out  4  current level, 1..MAX_LEVEL, drives the timer's level input.
REQ-013 showValid  out  1  high while showSym is presented.
REQ-014 showSym  out  2  symbol being presented.
REQ-015 gameOver  out  1  high in LOSE state.
REQ-016 win  out  1  high in WIN state.
REQ-017 state  out  3  encoded FSM state, for debug.

Function
REQ-018 FSM states: IDLE=0, ARM=1, WAIT_TMR=2, GEN=3, SHOW=4, INPUT=5, LOSE=6, WIN=7.
REQ-019 Start event is a startBtn 0->1 transition between consecutive cycles; IDLE, LOSE and WIN on start event -> ARM, with curLevel set to 1.
REQ-020 Start events in ARM..INPUT are ignored.
REQ-021 ARM: timerStart=1 for exactly that cycle; next state WAIT_TMR.
REQ-022 WAIT_TMR: on timerDone -> GEN; timerDone in any other state is ignored.
REQ-023 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every cycle in every state.
REQ-024 Sequence length L = curLevel+2 (3..11); storage 16 entries x 2 bits.
REQ-025 GEN: writes lfsr[1:0] to entry i on each of L consecutive cycles, i=0..L-1, then -> SHOW.
REQ-026 SHOW: entry i is presented on showSym with showValid=1 for one full tick1Hz period per entry, starting with entry 0; after the tick that ends entry L-1 -> INPUT with index 0.
REQ-027 guessValid outside INPUT is ignored.
REQ-028 INPUT: a guess matching entry idx advances idx; a mismatch -> LOSE; match at idx=L-1 -> level-up.
REQ-029 Level-up: if curLevel==MAX_LEVEL -> WIN, else curLevel+1 and -> ARM.
REQ-030 curLevel never exceeds MAX_LEVEL and never wraps.
REQ-031 A guess and tick1Hz in the same INPUT cycle: the guess is processed and the timeout counter clears.
REQ-032 LOSE and WIN hold until a start event or reset; showValid=0 and timerStart=0 there.

Reset
REQ-033 On reset: state=IDLE, curLevel=1, timerStart=0, showValid=0, showSym=0, gameOver=0, win=0, lfsr=LFSR_SEED, idx=0, timeout counter=0.
REQ-034 Reset asserted in any state, mid-sequence included, wins over every other event; the first post-reset start event needs startBtn low for at least one cycle after reset.

Configuration
REQ-035 Macro SYM_TIMEOUT_EN defined: in INPUT, INPUT_TIMEOUT consecutive tick1Hz pulses without a guess -> LOSE; the counter clears on each accepted guess and on entry to INPUT.
REQ-036 SYM_TIMEOUT_EN undefined: INPUT waits indefinitely; no timeout counter is implemented.

Verification
REQ-037 Reset, then startBtn rise -> one-cycle timerStart, curLevel=1, state=WAIT_TMR; timerDone pulse -> GEN lasts 3 cycles, then SHOW.
REQ-038 Level 1, 3 correct guesses taken from showSym during SHOW -> curLevel=2, timerStart pulse, next GEN lasts 4 cycles.
REQ-039 Level 1, second guess wrong -> gameOver=1 next cycle; further guesses are ignored; startBtn rise -> ARM with curLevel=1.
REQ-040 MAX_LEVEL=2, complete levels 1 and 2 correctly -> win=1, curLevel stays 2.
REQ-041 With SYM_TIMEOUT_EN: in INPUT, 5 ticks with no guess -> gameOver=1; a guess on the 5th tick cycle -> no LOSE. Without SYM_TIMEOUT_EN: 20 ticks idle -> still INPUT.
REQ-042 Reset asserted during SHOW at entry 2 -> next cycle state=IDLE, showValid=0, curLevel=1; timerDone pulse in IDLE -> no state change.
